apb_adder_regbank: RTL

APB3 slave register bank on the host side of the adder core's control FSM. Exposes operand, control, status and result registers to the bus. Issues the start request consumed by the control FSM and holds it until the FSM acknowledges. Captures the result on the FSM's write strobe and raises a done flag and an optional interrupt.

---
 rtl/apb_adder_regbank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/apb_adder_regbank.sv
// APB3 register bank fronting the adder core: operands, start/irq control,
// busy/done status and the captured result.
module apb_adder_regbank #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              ACLK,
    input  logic              ARSTn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              o_start,
    output logic [DATA_W-1:0] o_opa,
    output logic [DATA_W-1:0] o_opb,
    input  logic              i_is_busy,
    input  logic [DATA_W-1:0] i_result,
    input  logic              i_en_ctrl_write,
    input  logic              i_rst_start,
    output logic              o_irq
);

    localparam int unsigned OFF_W = 3;
    localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
    localparam logic [OFF_W-1:0] OFF_STATUS = 3'd1;
    localparam logic [OFF_W-1:0] OFF_OPA    = 3'd2;
    localparam logic [OFF_W-1:0] OFF_OPB    = 3'd3;
    localparam logic [OFF_W-1:0] OFF_RESULT = 3'd4;

    logic              r_start;
    logic              r_ie;
    logic              r_done;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_result;
    logic [31:0]       r_prdata;

    logic [OFF_W-1:0]  w_off;
    logic              w_hi_zero;
    logic              w_mapped;
    logic              w_setup_rd;
    logic              w_access;
    logic              w_wr_err;
    logic              w_commit;
    logic              w_locked;
    logic [31:0]       w_rdata;
    logic              w_unused;

    // Address decode: word offset from PADDR[4:2], everything above must be zero
    assign w_off      = PADDR[4:2];
    assign w_hi_zero  = ((PADDR >> 5) == '0);
    assign w_mapped   = w_hi_zero & (w_off <= OFF_RESULT);
    assign w_setup_rd = PSEL & ~PENABLE & ~PWRITE;
    assign w_access   = PSEL & PENABLE;
    assign w_locked   = i_is_busy | r_start;
    assign w_unused   = ^{PADDR[1:0], PWDATA};

    // Read mux, sampled into PRDATA on the setup edge
    always_comb begin
        w_rdata = 32'd0;
        if (w_mapped) begin
            case (w_off)
                OFF_CTRL:   w_rdata = {30'd0, r_ie, r_start};
                OFF_STATUS: w_rdata = {30'd0, r_done, i_is_busy};
                OFF_OPA:    w_rdata = 32'(r_opa);
                OFF_OPB:    w_rdata = 32'(r_opb);
                OFF_RESULT: w_rdata = 32'(r_result);
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    // Write refusal: operands and a new start are locked while an operation is in flight
    always_comb begin
        w_wr_err = 1'b0;
        if (!w_mapped) begin
            w_wr_err = 1'b1;
        end else begin
            case (w_off)
                OFF_CTRL:   w_wr_err = PWDATA[0] & w_locked;
                OFF_STATUS: w_wr_err = PWDATA[0];
                OFF_OPA:    w_wr_err = w_locked;
                OFF_OPB:    w_wr_err = w_locked;
                default:    w_wr_err = 1'b1;
            endcase
        end
    end

    assign w_commit = w_access & PWRITE & ~w_wr_err;
    assign PSLVERR  = w_access & (~w_mapped | (PWRITE & w_wr_err));

    always_ff @(posedge ACLK) begin
        if (!ARSTn) begin
            r_start  <= 1'b0;
            r_ie     <= 1'b0;
            r_done   <= 1'b0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_prdata <= 32'd0;
        end else begin
            if (i_rst_start) begin
                r_start <= 1'b0;
            end
            if (w_commit) begin
                case (w_off)
                    OFF_CTRL: begin
                        r_ie <= PWDATA[1];
                        if (PWDATA[0]) begin
                            r_start <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                    OFF_STATUS: if (PWDATA[1]) r_done <= 1'b0;
                    OFF_OPA:    r_opa <= PWDATA[DATA_W-1:0];
                    OFF_OPB:    r_opb <= PWDATA[DATA_W-1:0];
                    default:    ;
                endcase
            end
            // Capture strobe comes last so it wins over a same-edge DONE clear
            if (i_en_ctrl_write) begin
                r_result <= i_result;
                r_done   <= 1'b1;
            end
            if (w_setup_rd) begin
                r_prdata <= w_rdata;
            end
        end
    end

    assign PRDATA  = r_prdata;
    assign PREADY  = 1'b1;
    assign o_start = r_start;
    assign o_opa   = r_opa;
    assign o_opb   = r_opb;
    assign o_irq   = r_done & r_ie;

endmodule
